// File: rtl/fetch_stage_pkg.sv
// Shared constants and encodings for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  // sll $0,$0,0: decodes as SPECIAL and only ever writes $0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JR   = 2'b10;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // Redirect targets are always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load / bubble / hold control and field slicing.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid,
  output logic [5:0]  o_op_code,
  output logic [5:0]  o_funct_code,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [15:0] o_imm
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Load has priority over bubble; with neither asserted the register holds.
  // A bubble keeps the old pc_plus4, since only instr/valid matter downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else if (i_bubble) begin
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end
  end

  assign o_instr      = r_instr;
  assign o_pc_plus4   = r_pc_plus4;
  assign o_valid      = r_valid;
  assign o_op_code    = r_instr[31:26];
  assign o_funct_code = r_instr[5:0];
  assign o_rs         = r_instr[25:21];
  assign o_rt         = r_instr[20:16];
  assign o_rd         = r_instr[15:11];
  assign o_imm        = r_instr[15:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, redirect handling, IF/ID register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | normal fetch; fbuf parks a word returned during a stall
// ST_DRAIN | redirect arrived with a request outstanding; waiting for the
//          | stale word to return so it can be dropped before retargeting
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic [1:0]  i_jump,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_jr_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc_plus4,
  output logic        o_if_id_valid,
  output logic [5:0]  o_op_code,
  output logic [5:0]  o_funct_code,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [15:0] o_imm
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending_pc;
  logic [31:0]  r_fbuf;
  logic         r_fbuf_valid;

  fetch_state_e w_next_state;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_pending_next;
  logic [31:0]  w_fbuf_next;
  logic         w_fbuf_valid_next;
  logic         w_ifid_load;
  logic         w_ifid_bubble;
  logic [31:0]  w_ifid_instr;
  logic [31:0]  w_pc_plus4;
  logic         w_req;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_ifid_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_req      = (r_state == ST_DRAIN) || !r_fbuf_valid;

  // Request is masked while reset is held so nothing is issued from the reset PC early
  assign o_imem_req  = w_req && !i_rst;
  assign o_imem_addr = r_pc;

  // Redirect decode: jumps take priority over a taken branch; stall blocks all redirects
  always_comb begin
    w_redirect = 1'b0;
    w_target   = r_pc;
    if (!i_stall) begin
      if (i_jump == JUMP_J) begin
        w_redirect = 1'b1;
        w_target   = {w_ifid_pc_plus4[31:28], i_jump_index, 2'b00};
      end else if (i_jump == JUMP_JR) begin
        w_redirect = 1'b1;
        w_target   = word_align(i_jr_target);
      end else if (i_branch_taken) begin
        w_redirect = 1'b1;
        w_target   = word_align(i_branch_target);
      end
    end
  end

  // Next-state, next-PC and IF/ID control
  always_comb begin
    w_next_state      = r_state;
    w_pc_next         = r_pc;
    w_pending_next    = r_pending_pc;
    w_fbuf_next       = r_fbuf;
    w_fbuf_valid_next = r_fbuf_valid;
    w_ifid_load       = 1'b0;
    w_ifid_bubble     = 1'b0;
    w_ifid_instr      = r_fbuf;
    case (r_state)
      ST_FETCH: begin
        if (i_stall) begin
          if (i_imem_ready && !r_fbuf_valid) begin
            w_fbuf_next       = i_imem_rdata;
            w_fbuf_valid_next = 1'b1;
          end
        end else if (w_redirect) begin
          w_ifid_bubble     = 1'b1;
          w_fbuf_valid_next = 1'b0;
          if (w_req && !i_imem_ready) begin
            w_pending_next = w_target;
            w_next_state   = ST_DRAIN;
          end else begin
            w_pc_next = w_target;
          end
        end else if (r_fbuf_valid) begin
          w_ifid_load       = 1'b1;
          w_ifid_instr      = r_fbuf;
          w_pc_next         = w_pc_plus4;
          w_fbuf_valid_next = 1'b0;
        end else if (i_imem_ready) begin
          w_ifid_load  = 1'b1;
          w_ifid_instr = i_imem_rdata;
          w_pc_next    = w_pc_plus4;
        end else begin
          w_ifid_bubble = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_ifid_bubble = !i_stall;
        if (w_redirect) begin
          w_pending_next = w_target;
        end
        // The stale word is dropped; a redirect in the same cycle is the newest target
        if (i_imem_ready) begin
          w_pc_next    = w_redirect ? w_target : r_pending_pc;
          w_next_state = ST_FETCH;
        end
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // State, PC and fetch-buffer registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_pending_pc <= 32'h0;
      r_fbuf       <= 32'h0;
      r_fbuf_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_pc_next;
      r_pending_pc <= w_pending_next;
      r_fbuf       <= w_fbuf_next;
      r_fbuf_valid <= w_fbuf_valid_next;
    end
  end

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_ifid_load),
    .i_bubble     (w_ifid_bubble),
    .i_instr      (w_ifid_instr),
    .i_pc_plus4   (w_pc_plus4),
    .o_instr      (o_if_id_instr),
    .o_pc_plus4   (w_ifid_pc_plus4),
    .o_valid      (o_if_id_valid),
    .o_op_code    (o_op_code),
    .o_funct_code (o_funct_code),
    .o_rs         (o_rs),
    .o_rt         (o_rt),
    .o_rd         (o_rd),
    .o_imm        (o_imm)
  );

  assign o_if_id_pc_plus4 = w_ifid_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
module tb_fetch_stage;

  logic        i_clk;
  logic        i_rst;
  logic        i_stall;
  logic [1:0]  i_jump;
  logic [25:0] i_jump_index;
  logic [31:0] i_jr_target;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_if_id_instr;
  logic [31:0] o_if_id_pc_plus4;
  logic        o_if_id_valid;
  logic [5:0]  o_op_code;
  logic [5:0]  o_funct_code;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [15:0] o_imm;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_stall          (i_stall),
    .i_jump           (i_jump),
    .i_jump_index     (i_jump_index),
    .i_jr_target      (i_jr_target),
    .i_branch_taken   (i_branch_taken),
    .i_branch_target  (i_branch_target),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ready     (i_imem_ready),
    .i_imem_rdata     (i_imem_rdata),
    .o_if_id_instr    (o_if_id_instr),
    .o_if_id_pc_plus4 (o_if_id_pc_plus4),
    .o_if_id_valid    (o_if_id_valid),
    .o_op_code        (o_op_code),
    .o_funct_code     (o_funct_code),
    .o_rs             (o_rs),
    .o_rt             (o_rt),
    .o_rd             (o_rd),
    .o_imm            (o_imm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // jump and a taken branch must never be presented together
  always @(posedge i_clk) begin
    if (!i_rst && i_branch_taken && (i_jump == 2'b01 || i_jump == 2'b10)) begin
      n_fail++;
      $display("FAIL illegal_redirect jump=%b branch_taken=%b required exclusive", i_jump, i_branch_taken);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_stall         = 1'b0;
    i_jump          = 2'b00;
    i_jump_index    = 26'h0;
    i_jr_target     = 32'h0;
    i_branch_taken  = 1'b0;
    i_branch_target = 32'h0;
    i_imem_ready    = 1'b0;
    i_imem_rdata    = 32'h0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle_inputs();
    tick();
    n_checks++; if (o_imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr got %h exp %h", o_imem_addr, 32'h3000); end
    n_checks++; if (o_if_id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp %h", o_if_id_instr, 32'h0); end
    n_checks++; if (o_if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_pcp4 got %h exp %h", o_if_id_pc_plus4, 32'h0); end
    n_checks++; if (o_if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", o_if_id_valid); end
    n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", o_imem_req); end
    i_rst = 1'b0;
    #1;
    n_checks++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_release_req got %b exp 1", o_imem_req); end
  endtask

  task automatic test_zero_wait();
    i_imem_ready = 1'b1; i_imem_rdata = 32'h2008_0005;
    tick();
    n_checks++; if (o_if_id_instr !== 32'h2008_0005) begin n_fail++; $display("FAIL zw_instr got %h exp %h", o_if_id_instr, 32'h2008_0005); end
    n_checks++; if (o_if_id_pc_plus4 !== 32'h3004) begin n_fail++; $display("FAIL zw_pcp4 got %h exp %h", o_if_id_pc_plus4, 32'h3004); end
    n_checks++; if (o_if_id_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid got %b exp 1", o_if_id_valid); end
    n_checks++; if (o_op_code !== 6'h08) begin n_fail++; $display("FAIL zw_op got %h exp %h", o_op_code, 6'h08); end
    n_checks++; if (o_rt !== 5'd8 || o_rs !== 5'd0 || o_imm !== 16'h0005) begin n_fail++; $display("FAIL zw_fields got rs=%0d rt=%0d imm=%h exp rs=0 rt=8 imm=0005", o_rs, o_rt, o_imm); end
    n_checks++; if (o_imem_addr !== 32'h3004) begin n_fail++; $display("FAIL zw_addr got %h exp %h", o_imem_addr, 32'h3004); end
  endtask

  task automatic test_wait_states();
    i_imem_ready = 1'b0; i_imem_rdata = 32'hDEAD_0000;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (o_if_id_valid !== 1'b0 || o_if_id_instr !== 32'h0) begin n_fail++; $display("FAIL ws_bubble%0d got valid=%b instr=%h exp valid=0 instr=0", k, o_if_id_valid, o_if_id_instr); end
      n_checks++; if (o_imem_addr !== 32'h3004 || o_imem_req !== 1'b1) begin n_fail++; $display("FAIL ws_hold%0d got addr=%h req=%b exp addr=3004 req=1", k, o_imem_addr, o_imem_req); end
    end
    i_imem_ready = 1'b1; i_imem_rdata = 32'h8C09_0004;
    tick();
    n_checks++; if (o_if_id_instr !== 32'h8C09_0004 || o_if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ws_capture got instr=%h valid=%b exp 8c090004 valid=1", o_if_id_instr, o_if_id_valid); end
    n_checks++; if (o_if_id_pc_plus4 !== 32'h3008 || o_imem_addr !== 32'h3008) begin n_fail++; $display("FAIL ws_pc got pcp4=%h addr=%h exp 3008/3008", o_if_id_pc_plus4, o_imem_addr); end
    n_checks++; if (o_op_code !== 6'h23 || o_funct_code !== 6'h04) begin n_fail++; $display("FAIL ws_fields got op=%h funct=%h exp 23/04", o_op_code, o_funct_code); end
  endtask

  task automatic test_stall_fbuf();
    i_stall = 1'b1; i_imem_ready = 1'b1; i_imem_rdata = 32'h0109_5020;
    tick();
    n_checks++; if (o_if_id_instr !== 32'h8C09_0004 || o_if_id_pc_plus4 !== 32'h3008 || o_if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st_hold got instr=%h pcp4=%h valid=%b exp 8c090004/3008/1", o_if_id_instr, o_if_id_pc_plus4, o_if_id_valid); end
    n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req_after_capture got %b exp 0", o_imem_req); end
    // A second word on the bus must not overwrite the parked one
    i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_ready = 1'b0;
    // Redirect under stall is ignored
    i_jump = 2'b10; i_jr_target = 32'h0000_5000;
    tick();
    n_checks++; if (o_imem_addr !== 32'h3008 || o_if_id_instr !== 32'h8C09_0004) begin n_fail++; $display("FAIL st_hold3 got addr=%h instr=%h exp 3008/8c090004", o_imem_addr, o_if_id_instr); end
    i_jump = 2'b00; i_stall = 1'b0;
    #1;
    n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL st_release_req got %b exp 0", o_imem_req); end
    tick();
    n_checks++; if (o_if_id_instr !== 32'h0109_5020 || o_if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st_fbuf got instr=%h valid=%b exp 01095020/1", o_if_id_instr, o_if_id_valid); end
    n_checks++; if (o_if_id_pc_plus4 !== 32'h300C || o_imem_addr !== 32'h300C) begin n_fail++; $display("FAIL st_pc got pcp4=%h addr=%h exp 300c/300c", o_if_id_pc_plus4, o_imem_addr); end
    n_checks++; if (o_rd !== 5'd10 || o_funct_code !== 6'h20 || o_imem_req !== 1'b1) begin n_fail++; $display("FAIL st_fields got rd=%0d funct=%h req=%b exp 10/20/1", o_rd, o_funct_code, o_imem_req); end
  endtask

  task automatic test_jump();
    i_jump = 2'b01; i_jump_index = 26'h000_0C10;
    i_imem_ready = 1'b1; i_imem_rdata = 32'hBADB_AD00;
    tick();
    n_checks++; if (o_if_id_valid !== 1'b0 || o_if_id_instr !== 32'h0) begin n_fail++; $display("FAIL j_bubble got valid=%b instr=%h exp 0/0", o_if_id_valid, o_if_id_instr); end
    n_checks++; if (o_imem_addr !== 32'h3040) begin n_fail++; $display("FAIL j_target got %h exp %h", o_imem_addr, 32'h3040); end
    i_jump = 2'b00; i_imem_rdata = 32'h3C01_1234;
    tick();
    n_checks++; if (o_if_id_instr !== 32'h3C01_1234 || o_if_id_pc_plus4 !== 32'h3044 || o_if_id_valid !== 1'b1) begin n_fail++; $display("FAIL j_first got instr=%h pcp4=%h valid=%b exp 3c011234/3044/1", o_if_id_instr, o_if_id_pc_plus4, o_if_id_valid); end
  endtask

  task automatic test_jr();
    i_jump = 2'b10; i_jr_target = 32'h0000_3203;
    i_imem_ready = 1'b1; i_imem_rdata = 32'hBADB_AD01;
    tick();
    n_checks++; if (o_imem_addr !== 32'h3200 || o_if_id_valid !== 1'b0) begin n_fail++; $display("FAIL jr_target got addr=%h valid=%b exp 3200/0", o_imem_addr, o_if_id_valid); end
    i_jump = 2'b00; i_imem_rdata = 32'h03E0_0008;
    tick();
    n_checks++; if (o_if_id_instr !== 32'h03E0_0008 || o_if_id_pc_plus4 !== 32'h3204) begin n_fail++; $display("FAIL jr_first got instr=%h pcp4=%h exp 03e00008/3204", o_if_id_instr, o_if_id_pc_plus4); end
    n_checks++; if (o_rs !== 5'd31 || o_funct_code !== 6'h08) begin n_fail++; $display("FAIL jr_fields got rs=%0d funct=%h exp 31/08", o_rs, o_funct_code); end
  endtask

  task automatic test_branch_drain();
    i_imem_ready = 1'b0; i_branch_taken = 1'b1; i_branch_target = 32'h0000_3100;
    tick();
    n_checks++; if (o_imem_addr !== 32'h3204 || o_imem_req !== 1'b1 || o_if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_drain_enter got addr=%h req=%b valid=%b exp 3204/1/0", o_imem_addr, o_imem_req, o_if_id_valid); end
    i_branch_taken = 1'b0;
    tick();
    n_checks++; if (o_imem_addr !== 32'h3204 || o_if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_drain_wait got addr=%h valid=%b exp 3204/0", o_imem_addr, o_if_id_valid); end
    i_imem_ready = 1'b1; i_imem_rdata = 32'hFFFF_FFFF;
    tick();
    n_checks++; if (o_imem_addr !== 32'h3100 || o_if_id_valid !== 1'b0 || o_if_id_instr !== 32'h0) begin n_fail++; $display("FAIL br_discard got addr=%h valid=%b instr=%h exp 3100/0/0", o_imem_addr, o_if_id_valid, o_if_id_instr); end
    i_imem_rdata = 32'h1000_FFFF;
    tick();
    n_checks++; if (o_if_id_instr !== 32'h1000_FFFF || o_if_id_pc_plus4 !== 32'h3104 || o_if_id_valid !== 1'b1) begin n_fail++; $display("FAIL br_first got instr=%h pcp4=%h valid=%b exp 1000ffff/3104/1", o_if_id_instr, o_if_id_pc_plus4, o_if_id_valid); end
  endtask

  task automatic test_drain_overwrite();
    i_imem_ready = 1'b0; i_branch_taken = 1'b1; i_branch_target = 32'h0000_3400;
    tick();
    i_branch_taken = 1'b0; i_jump = 2'b10; i_jr_target = 32'h0000_3300;
    tick();
    n_checks++; if (o_imem_addr !== 32'h3104) begin n_fail++; $display("FAIL ow_hold got %h exp %h", o_imem_addr, 32'h3104); end
    i_jump = 2'b00; i_imem_ready = 1'b1; i_imem_rdata = 32'hAAAA_5555;
    tick();
    n_checks++; if (o_imem_addr !== 32'h3300 || o_if_id_valid !== 1'b0) begin n_fail++; $display("FAIL ow_target got addr=%h valid=%b exp 3300/0", o_imem_addr, o_if_id_valid); end
  endtask

  task automatic test_reset_mid_drain();
    i_imem_ready = 1'b0; i_branch_taken = 1'b1; i_branch_target = 32'h0000_3500;
    tick();
    i_branch_taken = 1'b0;
    #3;
    i_rst = 1'b1;
    #1;
    n_checks++; if (o_imem_addr !== 32'h3000 || o_if_id_valid !== 1'b0 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_async got addr=%h valid=%b req=%b exp 3000/0/0", o_imem_addr, o_if_id_valid, o_imem_req); end
    i_imem_ready = 1'b1; i_imem_rdata = 32'h5555_AAAA;
    tick();
    n_checks++; if (o_if_id_valid !== 1'b0 || o_imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rd_held got valid=%b addr=%h exp 0/3000", o_if_id_valid, o_imem_addr); end
    i_rst = 1'b0; i_imem_rdata = 32'h2008_0005;
    tick();
    n_checks++; if (o_if_id_instr !== 32'h2008_0005 || o_if_id_pc_plus4 !== 32'h3004 || o_imem_addr !== 32'h3004) begin n_fail++; $display("FAIL rd_refetch got instr=%h pcp4=%h addr=%h exp 20080005/3004/3004", o_if_id_instr, o_if_id_pc_plus4, o_imem_addr); end
  endtask

  task automatic test_reset_with_fbuf();
    i_stall = 1'b1; i_imem_ready = 1'b1; i_imem_rdata = 32'hCAFE_0000;
    tick();
    n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_parked got req=%b exp 0", o_imem_req); end
    i_rst = 1'b1;
    #1;
    i_rst = 1'b0; i_stall = 1'b0; i_imem_ready = 1'b0;
    #1;
    n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rf_cleared got req=%b addr=%h exp 1/3000", o_imem_req, o_imem_addr); end
    tick();
    n_checks++; if (o_if_id_valid !== 1'b0 || o_if_id_instr !== 32'h0 || o_imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rf_no_residue got valid=%b instr=%h addr=%h exp 0/0/3000", o_if_id_valid, o_if_id_instr, o_imem_addr); end
  endtask

  task automatic test_pc_wrap();
    i_branch_taken = 1'b1; i_branch_target = 32'hFFFF_FFFE;
    i_imem_ready = 1'b1; i_imem_rdata = 32'h0;
    tick();
    n_checks++; if (o_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_align got %h exp %h", o_imem_addr, 32'hFFFF_FFFC); end
    i_branch_taken = 1'b0; i_imem_rdata = 32'h1111_1111;
    tick();
    n_checks++; if (o_if_id_pc_plus4 !== 32'h0 || o_imem_addr !== 32'h0 || o_if_id_valid !== 1'b1) begin n_fail++; $display("FAIL wr_wrap got pcp4=%h addr=%h valid=%b exp 0/0/1", o_if_id_pc_plus4, o_imem_addr, o_if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_fbuf();
    test_jump();
    test_jr();
    test_branch_drain();
    test_drain_overwrite();
    test_reset_mid_drain();
    test_reset_with_fbuf();
    test_pc_wrap();
    idle_inputs();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the control unit. It owns the PC, issues requests to instruction memory with a ready handshake, and applies redirects from the decode stage (J/JAL/JR, taken BEQ/BNE). It presents the decoded instruction fields (op_code, funct_code, rs/rt/rd, imm) that the control unit and register file consume. There are no branch delay slots: every redirect squashes the wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0), which decodes as SPECIAL and writes $0 only.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  from hazard unit; holds PC and IF/ID.
jump  in  2  from control unit: 01 = J/JAL, 10 = JR, 00 or 11 = none.
jump_index  in  26  instr[25:0] of the ID instruction.
jr_target  in  32  forwarded rs value for JR.
branch_taken  in  1  ID branch resolved taken.
branch_target  in  32  ID-computed branch target.
imem_req  out  1  fetch request.
imem_addr  out  32  word address = pc.
imem_ready  in  1  imem_rdata valid this cycle.
imem_rdata  in  32  instruction word.
if_id_instr  out  32  registered instruction.
if_id_pc_plus4  out  32  registered PC+4.
if_id_valid  out  1  0 = bubble.
op_code  out  6  if_id_instr[31:26].
funct_code  out  6  if_id_instr[5:0].
rs, rt, rd  out  5 each  instruction fields [25:21], [20:16], [15:11].
imm  out  16  if_id_instr[15:0].

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc_plus4=0; if_id_valid=0.
  - fbuf_valid=0; state=FETCH; imem_req=0.
- States:
  - FETCH: normal operation.
  - DRAIN: a redirect arrived while a request was outstanding.
- imem_req=1 in FETCH when fbuf_valid=0, and always in DRAIN. imem_addr=pc and must stay stable until imem_ready=1.
- Redirect is qualified only when stall=0. Priority: jump (01, 10) over branch_taken.
  - 01 target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
  - 10 target = jr_target.
  - branch target = branch_target.
  - Simultaneous jump!=00 and branch_taken is illegal; the bench asserts it never occurs.
- FETCH, stall=0, no redirect:
  - fbuf_valid=1: IF/ID <= {fbuf, pc+4, 1}; pc <= pc+4; fbuf_valid <= 0.
  - else imem_ready=1: IF/ID <= {imem_rdata, pc+4, 1}; pc <= pc+4.
  - else: IF/ID <= bubble (NOP_INSTR, valid 0); pc holds.
- FETCH, stall=1:
  - IF/ID and pc hold.
  - If imem_ready=1 and fbuf_valid=0: fbuf <= imem_rdata; fbuf_valid <= 1.
  - A redirect input is ignored.
- FETCH, stall=0, redirect:
  - IF/ID <= bubble; fbuf_valid <= 0.
  - If imem_req=1 and imem_ready=0: pending_pc <= target; state <= DRAIN; pc holds.
  - Otherwise pc <= target, and any returned data is dropped.
- DRAIN:
  - IF/ID loads bubble unless stall=1.
  - On imem_ready=1: data discarded; pc <= pending_pc; state <= FETCH.
  - A further qualified redirect in DRAIN overwrites pending_pc.
- PC arithmetic is 32-bit modulo: pc+4 wraps 32'hFFFF_FFFC -> 32'h0. Bits [1:0] of redirect targets are forced to 0.
- Latency: a fetch with immediate ready appears on IF/ID one clock later. Redirect to first target instruction on IF/ID is 2 clocks with zero-wait memory.
- Reset asserted mid-DRAIN or with fbuf_valid=1: all state cleared immediately, with no residual capture.

Decomposition:
- Shared package/header additions: NOP_INSTR, RESET_PC default, jump encodings (JUMP_NONE=00, JUMP_J=01, JUMP_JR=10), fetch state encodings.
- One natural sub-module, if_id_reg: the IF/ID register with load/hold/bubble controls and field slicing. The PC/next-PC logic and FSM stay top-level.

Test Plan:
- Zero-wait, reset released, imem returns 0x20080005 at 0x3000 -> next clock: if_id_instr=0x20080005, pc_plus4=0x3004, valid=1, op_code=0x08; pc=0x3004.
- imem_ready low 2 cycles at 0x3004 -> 2 bubbles (valid=0, instr=0); pc holds 0x3004; word captured on the 3rd cycle.
- stall=1 for 3 cycles while ready=1 -> IF/ID and pc hold; fbuf captures; req=0 after capture; on release, IF/ID gets the fbuf word with no new imem access that cycle.
- jump=01, jump_index=0x0000C10, if_id_pc_plus4=0x3008 -> IF/ID bubble; pc=0x0000_3040; next instruction comes from 0x3040.
- branch_taken=1, target 0x3100, while request pending with ready=0 -> DRAIN; returned word discarded; pc=0x3100; no wrong-path valid=1.
- rst pulsed mid-DRAIN with fbuf_valid=1 -> pc=0x3000, valid=0, imem_req=0 during reset; normal fetch from 0x3000 after release.
